// File: rtl/memwb_prefetch_pkg.sv
// Shared sizing and FSM encoding for the memwb read-ahead buffer.
package memwb_prefetch_pkg;
  localparam int PF_ADDRBITS  = 26;
  localparam int PF_DATABITS  = 16;
  localparam int PF_DEPTH     = 8;
  localparam int PF_DEPTHBITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PASS = 2'd2
  } state_e;
endpackage

// File: rtl/memwb_prefetch_pf_buf.sv
// Read-ahead storage: DEPTH words plus per-word valid bits; clear wins over a same-cycle set.
module pf_buf #(
  parameter int DEPTH     = 8,
  parameter int DEPTHBITS = 3,
  parameter int DATABITS  = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 wr_i,
  input  logic                 set_i,
  input  logic                 clr_i,
  input  logic [DEPTHBITS-1:0] widx_i,
  input  logic [DATABITS-1:0]  wdat_i,
  input  logic [DEPTHBITS-1:0] ridx_i,
  output logic [DATABITS-1:0]  rdat_o,
  output logic [DEPTH-1:0]     vld_o
);
  logic [DEPTH-1:0][DATABITS-1:0] mem_q;
  logic [DEPTH-1:0]               vld_q, vld_d;

  always_comb begin
    vld_d = vld_q;
    if (wr_i && set_i) vld_d[widx_i] = 1'b1;
    if (clr_i)         vld_d = '0;
  end

  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) vld_q <= '0;
    else          vld_q <= vld_d;

  always_ff @(posedge clk_i)
    if (wr_i) mem_q[widx_i] <= wdat_i;

  assign rdat_o = mem_q[ridx_i];
  assign vld_o  = vld_q;
endmodule

// File: rtl/memwb_prefetch.sv
// Read-ahead buffer between the QSPI memwb master and the NOR slave: misses burst-fill DEPTH words,
// writes pass through and invalidate.
module memwb_prefetch
  import memwb_prefetch_pkg::*;
#(
  parameter int ADDRBITS  = PF_ADDRBITS,
  parameter int DATABITS  = PF_DATABITS,
  parameter int DEPTH     = PF_DEPTH,
  parameter int DEPTHBITS = PF_DEPTHBITS
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                pf_en_i,
  input  logic                inval_i,
  input  logic                s_cyc_i,
  input  logic                s_stb_i,
  input  logic                s_we_i,
  input  logic [ADDRBITS-1:0] s_adr_i,
  input  logic [DATABITS-1:0] s_dat_i,
  output logic [DATABITS-1:0] s_dat_o,
  output logic                s_ack_o,
  output logic                s_err_o,
  output logic                s_stall_o,
  output logic                m_cyc_o,
  output logic                m_stb_o,
  output logic                m_we_o,
  output logic [ADDRBITS-1:0] m_adr_o,
  output logic [DATABITS-1:0] m_dat_o,
  input  logic [DATABITS-1:0] m_dat_i,
  input  logic                m_ack_i,
  input  logic                m_err_i,
  input  logic                m_stall_i
);
  localparam int CW = DEPTHBITS + 1;

  state_e              state_q, state_d;
  logic [ADDRBITS-1:0] base_q, base_d, wadr_q, wadr_d;
  logic [DATABITS-1:0] wdat_q, wdat_d, dat_q, dat_d;
  logic [CW-1:0]       iss_q, iss_d, rcv_q, rcv_d;
  logic                pf_q, pf_d, pend_q, pend_d, invp_q, invp_d;
  logic                ack_q, ack_d, err_q, err_d, sdone_q, sdone_d;
  logic                buf_wr, buf_clr, req, hit, beat_out, last;
  logic [ADDRBITS-1:0] off;
  logic [CW-1:0]       nbeats;
  logic [DEPTH-1:0]    vld;
  logic [DATABITS-1:0] rdat;

  assign req      = s_cyc_i & s_stb_i & (state_q == ST_IDLE);
  assign off      = s_adr_i - base_q;
  // Bypass mode never serves from the buffer; a same-cycle invalidate forces a miss.
  assign hit      = (off < ADDRBITS'(DEPTH)) && vld[off[DEPTHBITS-1:0]] && pf_en_i && !inval_i;
  assign nbeats   = pf_q ? CW'(DEPTH) : CW'(1);
  assign beat_out = (iss_q != rcv_q);
  assign last     = (rcv_q + CW'(1)) == nbeats;

  pf_buf #(.DEPTH(DEPTH), .DEPTHBITS(DEPTHBITS), .DATABITS(DATABITS)) u_buf (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .wr_i   (buf_wr),
    .set_i  (pf_q),
    .clr_i  (buf_clr),
    .widx_i (rcv_q[DEPTHBITS-1:0]),
    .wdat_i (m_dat_i),
    .ridx_i (off[DEPTHBITS-1:0]),
    .rdat_o (rdat),
    .vld_o  (vld)
  );

  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state_q <= ST_IDLE;
      base_q  <= '0; wadr_q <= '0; wdat_q <= '0; dat_q <= '0;
      iss_q   <= '0; rcv_q  <= '0;
      pf_q    <= 1'b0; pend_q <= 1'b0; invp_q <= 1'b0;
      ack_q   <= 1'b0; err_q  <= 1'b0; sdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d; wadr_q <= wadr_d; wdat_q <= wdat_d; dat_q <= dat_d;
      iss_q   <= iss_d;  rcv_q  <= rcv_d;
      pf_q    <= pf_d;   pend_q <= pend_d; invp_q <= invp_d;
      ack_q   <= ack_d;  err_q  <= err_d;  sdone_q <= sdone_d;
    end

  always_comb begin
    state_d = state_q;
    base_d = base_q; wadr_d = wadr_q; wdat_d = wdat_q; dat_d = dat_q;
    iss_d = iss_q; rcv_d = rcv_q; pf_d = pf_q; pend_d = pend_q; invp_d = invp_q;
    sdone_d = sdone_q; ack_d = 1'b0; err_d = 1'b0; buf_wr = 1'b0; buf_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        invp_d = 1'b0;
        if (inval_i) buf_clr = 1'b1;
        if (req && s_we_i) begin
          buf_clr = 1'b1; wadr_d = s_adr_i; wdat_d = s_dat_i; sdone_d = 1'b0;
          state_d = ST_PASS;
        end else if (req && hit) begin
          ack_d = 1'b1; dat_d = rdat;
        end else if (req) begin
          buf_clr = 1'b1; base_d = s_adr_i; pend_d = 1'b1; pf_d = pf_en_i;
          iss_d = '0; rcv_d = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (inval_i) invp_d = 1'b1;
        pend_d = pend_q & s_cyc_i;
        if (m_stb_o && !m_stall_i) iss_d = iss_q + CW'(1);
        if (beat_out && m_err_i) begin
          buf_clr = 1'b1; err_d = pend_d; pend_d = 1'b0; invp_d = 1'b0;
          state_d = ST_IDLE;
        end else if (beat_out && m_ack_i) begin
          buf_wr = 1'b1; rcv_d = rcv_q + CW'(1);
          if (rcv_q == '0 && pend_d) begin
            ack_d = 1'b1; dat_d = m_dat_i;
          end
          pend_d = 1'b0;
          if (last) begin
            buf_clr = invp_d; invp_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_PASS: begin
        if (inval_i) invp_d = 1'b1;
        if (m_stb_o && !m_stall_i) sdone_d = 1'b1;
        if (sdone_q && (m_ack_i || m_err_i)) begin
          ack_d = !m_err_i; err_d = m_err_i;
          buf_clr = invp_d; invp_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_stall_o = 1'b0; m_cyc_o = 1'b0; m_stb_o = 1'b0; m_we_o = 1'b0;
    m_adr_o = '0; m_dat_o = '0;
    unique case (state_q)
      ST_FILL: begin
        s_stall_o = 1'b1; m_cyc_o = 1'b1;
        m_stb_o   = (iss_q < nbeats);
        m_adr_o   = base_q + ADDRBITS'(iss_q);
      end
      ST_PASS: begin
        s_stall_o = 1'b1; m_cyc_o = 1'b1; m_we_o = 1'b1;
        m_stb_o   = !sdone_q;
        m_adr_o   = wadr_q; m_dat_o = wdat_q;
      end
      default: ;
    endcase
  end

  assign s_ack_o = ack_q;
  assign s_err_o = err_q;
  assign s_dat_o = dat_q;
endmodule
